// File: rtl/ir_err_compute_if.sv
// Bundle between the IR sensor interface (master) and the steering-error block (slave).
interface ir_err_compute_if;
  logic        IR_vld;
  logic        line_present;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3;
  logic [11:0] IR_L0, IR_L1, IR_L2, IR_L3;
  logic [11:0] error;
  logic        err_vld;
  logic        busy;
  logic        line_lost;
  logic        overrun;

  modport master (
    output IR_vld, line_present, IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3,
    input  error, err_vld, busy, line_lost, overrun
  );

  modport slave (
    input  IR_vld, line_present, IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3,
    output error, err_vld, busy, line_lost, overrun
  );
endinterface

// File: rtl/ir_err_compute.sv
// Weighted IR line-position error, one channel accumulated per clock, saturated to 12 bits.
// Optional first-order error smoothing when ERR_FILT_EN is defined.
//
// state | meaning
// IDLE  | waiting for an IR_vld rising edge
// ACCUM | adding one weighted snapshot channel per clock (R0..R3, L0..L3)
// OUT   | registering the saturated error and pulsing err_vld
module ir_err_compute #(
  parameter int SHIFT = 3
) (
  input logic            clk,
  input logic            rst_n,
  ir_err_compute_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t             state, state_nxt;
  logic               vld_q;
  logic               ir_rise;
  logic [2:0]         cnt;
  logic [11:0]        snap [8];
  logic signed [16:0] acc;
  logic signed [16:0] term;
  logic signed [16:0] mag;
  logic [11:0]        err_new;
  logic [11:0]        err_next;
  logic               snap_en, acc_en, out_en, lost_set, ovr_set;

  function automatic logic [11:0] sat12(input logic signed [16:0] v);
    if (v > 17'sd2047)       return 12'h7FF;
    else if (v < -17'sd2048) return 12'h800;
    else                     return v[11:0];
  endfunction

  assign ir_rise  = bus.IR_vld & ~vld_q;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ir_rise && bus.line_present) state_nxt = ACCUM;
      ACCUM:   if (cnt == 3'd7) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_en  = 1'b0;
    acc_en   = 1'b0;
    out_en   = 1'b0;
    lost_set = 1'b0;
    ovr_set  = 1'b0;
    case (state)
      IDLE: begin
        snap_en  = ir_rise & bus.line_present;
        lost_set = ir_rise & ~bus.line_present;
      end
      ACCUM: begin
        acc_en  = 1'b1;
        ovr_set = ir_rise;
      end
      OUT: begin
        out_en  = 1'b1;
        ovr_set = ir_rise;
      end
      default: ;
    endcase
  end

  // cnt[1:0] is the weight exponent, cnt[2] selects the negatively weighted left side
  always_comb begin
    mag  = {5'b0, snap[cnt]} << cnt[1:0];
    term = cnt[2] ? -mag : mag;
  end

  assign err_new = sat12(acc >>> SHIFT);

`ifdef ERR_FILT_EN
  logic signed [12:0] diff;
  logic signed [12:0] diff_sh;
  logic signed [13:0] filt;

  always_comb begin
    diff     = {err_new[11], err_new} - {bus.error[11], bus.error};
    diff_sh  = diff >>> 2;
    filt     = {{2{bus.error[11]}}, bus.error} + {diff_sh[12], diff_sh};
    err_next = sat12({{3{filt[13]}}, filt});
  end
`else
  always_comb err_next = err_new;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q         <= 1'b0;
      cnt           <= 3'd0;
      acc           <= '0;
      bus.error     <= '0;
      bus.err_vld   <= 1'b0;
      bus.line_lost <= 1'b0;
      bus.overrun   <= 1'b0;
      for (int i = 0; i < 8; i++) snap[i] <= '0;
    end else begin
      vld_q       <= bus.IR_vld;
      bus.err_vld <= out_en;
      if (snap_en) begin
        snap[0] <= bus.IR_R0;
        snap[1] <= bus.IR_R1;
        snap[2] <= bus.IR_R2;
        snap[3] <= bus.IR_R3;
        snap[4] <= bus.IR_L0;
        snap[5] <= bus.IR_L1;
        snap[6] <= bus.IR_L2;
        snap[7] <= bus.IR_L3;
        acc     <= '0;
        cnt     <= 3'd0;
      end else if (acc_en) begin
        acc <= acc + term;
        cnt <= cnt + 3'd1;
      end
      if (out_en) bus.error <= err_next;
      if (lost_set)    bus.line_lost <= 1'b1;
      else if (out_en) bus.line_lost <= 1'b0;
      if (ovr_set) bus.overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_err_compute.sv
// Randomized + directed bench for ir_err_compute against an arithmetic reference model.
module tb_ir_err_compute;
  localparam int SHIFT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_err_compute_if bus();

  ir_err_compute #(.SHIFT(SHIFT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int model_err = 0;
  int exp_ovr = 0;
  int r [4];
  int l [4];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat12(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // position error: right side pulls positive, left negative, weights 1/2/4/8
  function automatic int model_next(input int prev);
    int s, n;
    s = 0;
    for (int i = 0; i < 4; i++) s += (r[i] - l[i]) * (1 << i);
    n = sat12(s >>> SHIFT);
`ifdef ERR_FILT_EN
    return sat12(prev + ((n - prev) >>> 2));
`else
    return n;
`endif
  endfunction

  task automatic drive_inputs();
    bus.IR_R0 = 12'(r[0]); bus.IR_R1 = 12'(r[1]); bus.IR_R2 = 12'(r[2]); bus.IR_R3 = 12'(r[3]);
    bus.IR_L0 = 12'(l[0]); bus.IR_L1 = 12'(l[1]); bus.IR_L2 = 12'(l[2]); bus.IR_L3 = 12'(l[3]);
  endtask

  task automatic clear_vals();
    for (int i = 0; i < 4; i++) begin r[i] = 0; l[i] = 0; end
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 4; i++) begin
      r[i] = int'($urandom_range(0, 4095));
      l[i] = int'($urandom_range(0, 4095));
    end
    if ($urandom_range(0, 3) == 0) for (int i = 0; i < 4; i++) r[i] = 4095;
    else if ($urandom_range(0, 3) == 0) for (int i = 0; i < 4; i++) l[i] = 4095;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.err_vld) pulses++;
    end
  endtask

  task automatic check_err(input string tag);
    check(tag, int'($signed(bus.error)), model_err);
  endtask

  // one full computation; with ovr set, inputs change at cycle 2 and IR_vld re-rises at cycle 3
  task automatic run_set(input string tag, input bit ovr);
    int cyc, pulses;
    drive_inputs();
    bus.line_present = 1'b1;
    bus.IR_vld = 1'b1;
    model_err = model_next(model_err);
    if (ovr) exp_ovr = 1;
    @(posedge clk); #1;
    check({tag, "_busy_hi"}, int'(bus.busy), 1);
    bus.IR_vld = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (ovr && cyc == 2) begin rand_vals(); drive_inputs(); end
      if (ovr && cyc == 3) bus.IR_vld = 1'b1;
      if (ovr && cyc == 4) bus.IR_vld = 1'b0;
    end while (!bus.err_vld && cyc < 20);
    bus.IR_vld = 1'b0;
    check({tag, "_latency"}, cyc, 9);
    check_err({tag, "_error"});
    check({tag, "_overrun"}, int'(bus.overrun), exp_ovr);
    check({tag, "_line_lost"}, int'(bus.line_lost), 0);
    @(posedge clk); #1;
    check({tag, "_vld_one_cycle"}, int'(bus.err_vld), 0);
    check({tag, "_busy_lo"}, int'(bus.busy), 0);
    count_pulses(10, pulses);
    check({tag, "_extra_vld"}, pulses, 0);
  endtask

  task automatic lost_set_event();
    int pulses;
    drive_inputs();
    bus.line_present = 1'b0;
    bus.IR_vld = 1'b1;
    @(posedge clk); #1;
    bus.IR_vld = 1'b0;
    check("lost_busy", int'(bus.busy), 0);
    count_pulses(12, pulses);
    check("lost_no_vld", pulses, 0);
    check("lost_flag", int'(bus.line_lost), 1);
    check_err("lost_err_held");
    bus.line_present = 1'b1;
  endtask

  initial begin
    int pulses;
    bus.IR_vld = 1'b0;
    bus.line_present = 1'b1;
    clear_vals();
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_error", int'(bus.error), 0);
    check("rst_err_vld", int'(bus.err_vld), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_line_lost", int'(bus.line_lost), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    clear_vals(); r[3] = 'h100;  run_set("r3_100", 1'b0);
    run_set("r3_100_again", 1'b0);
    clear_vals(); l[1] = 'h040;  run_set("l1_040", 1'b0);
    clear_vals(); r[3] = 'hFFF;  run_set("r3_sat", 1'b0);
    clear_vals(); l[3] = 'hFFF;  run_set("l3_sat", 1'b0);
    for (int i = 0; i < 4; i++) begin r[i] = 'h800; l[i] = 'h800; end
    run_set("all_800", 1'b0);
    lost_set_event();
    clear_vals(); r[3] = 'h100; r[0] = 'h7; run_set("overrun", 1'b1);

    // reset partway through accumulation
    clear_vals(); r[2] = 'h300; drive_inputs();
    bus.IR_vld = 1'b1;
    @(posedge clk); #1;
    bus.IR_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_err = 0;
    exp_ovr = 0;
    check("midrst_error", int'(bus.error), 0);
    check("midrst_err_vld", int'(bus.err_vld), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_line_lost", int'(bus.line_lost), 0);
    check("midrst_overrun", int'(bus.overrun), 0);
    count_pulses(2, pulses);
    rst_n = 1'b1;
    count_pulses(12, pulses);
    check("midrst_no_vld", pulses, 0);
    run_set("after_rst", 1'b0);

    // IR_vld held high counts once and is not an overrun
    clear_vals(); l[0] = 'h123; r[1] = 'h456; drive_inputs();
    model_err = model_next(model_err);
    bus.IR_vld = 1'b1;
    count_pulses(30, pulses);
    bus.IR_vld = 1'b0;
    check("held_one_vld", pulses, 1);
    check_err("held_error");
    check("held_overrun", int'(bus.overrun), 0);
    @(posedge clk); #1;

    repeat (25) begin
      rand_vals();
      run_set("rand", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
